online_digit_serializer: RTL

- Transmit end of the digit-serial operand interface used by the online datapath (multiplier, adder, divider, FIFOs).
- Accepts one parallel two's-complement operand pair (x, b) per valid/ready handshake.
- Emits the pair MSD-first as 2-bit signed digits, one digit per clock, with a level `enable` for the downstream online pipeline.
- Appends PAD zero digits per frame to flush the downstream online delay. Supports back-to-back frames with no gap.

---
 rtl/online_pkg.sv | 29 ++
 rtl/online_digit_lane.sv | 44 ++++
 rtl/online_digit_serializer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/online_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | online_pkg : digit encodings and serializer state type                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package online_pkg;

  localparam int DIGIT_W = 2;

  localparam logic [DIGIT_W-1:0] DIG_POS  = 2'b10;
  localparam logic [DIGIT_W-1:0] DIG_NEG  = 2'b01;
  localparam logic [DIGIT_W-1:0] DIG_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PADS = 2'd2
  } ser_state_t;

  // Inverting both rails of a {p,m} digit negates its value.
  function automatic logic [DIGIT_W-1:0] negate_digit(
    input logic [DIGIT_W-1:0] d,
    input logic               neg
  );
    return neg ? ~d : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/online_digit_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | online_digit_lane : one operand lane, shift register to signed digits    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module online_digit_lane
  import online_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               asyn_reset,
  input  logic               load,
  input  logic               shift,
  input  logic               flush,
  input  logic [WIDTH-1:0]   word,
  input  logic               neg,
  output logic [DIGIT_W-1:0] digit
);

  logic [WIDTH-1:0] shreg;
  logic             neg_r;

  // The sign digit is emitted on load; shreg keeps the remaining fraction
  // bits MSB-aligned so the next data digit is always shreg[WIDTH-1].
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      shreg <= '0;
      neg_r <= 1'b0;
      digit <= DIG_ZERO;
    end else if (load) begin
      shreg <= {word[WIDTH-2:0], 1'b0};
      neg_r <= neg;
      digit <= negate_digit(word[WIDTH-1] ? DIG_NEG : DIG_ZERO, neg);
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      digit <= negate_digit(shreg[WIDTH-1] ? DIG_POS : DIG_ZERO, neg_r);
    end else if (flush) begin
      digit <= DIG_ZERO;
    end
  end

endmodule
`default_nettype wire

// File: rtl/online_digit_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | online_digit_serializer : parallel operand pair to MSD-first digit frames|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module online_digit_serializer
  import online_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PAD   = 4
) (
  input  logic               clk,
  input  logic               asyn_reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_neg_b,
  output logic [DIGIT_W-1:0] x_digit,
  output logic [DIGIT_W-1:0] b_digit,
  output logic               enable,
  output logic               frame_start,
  output logic               frame_last,
  output logic               busy
);

  localparam int L     = WIDTH + PAD;
  localparam int IDX_W = (L > 1) ? $clog2(L) : 1;

  ser_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             next_is_data;

  logic [WIDTH-1:0] hold_x;
  logic [WIDTH-1:0] hold_b;
  logic             hold_neg;
  logic             hold_full;

  logic             accept;
  logic             in_frame;
  logic             advance;
  logic             load_hold;
  logic             load_direct;
  logic             lane_load;
  logic             lane_shift;
  logic             lane_flush;
  logic [WIDTH-1:0] lane_x;
  logic [WIDTH-1:0] lane_b;
  logic             lane_neg;

  assign in_ready = ~hold_full;
  assign accept   = in_valid & in_ready;
  assign in_frame = (state != IDLE);
  assign busy     = in_frame | hold_full;

  assign idx_next     = idx + 1'b1;
  assign next_is_data = (32'(idx_next) < 32'(WIDTH));

  // frame_last is only ever set inside a frame, so it marks the closing edge.
  assign advance     = in_frame & ~frame_last;
  assign load_hold   = frame_last & hold_full;
  assign load_direct = accept & (~in_frame | frame_last);
  assign lane_load   = load_hold | load_direct;
  assign lane_shift  = advance & next_is_data;
  assign lane_flush  = (advance & ~next_is_data) | (frame_last & ~lane_load);

  assign lane_x   = load_hold ? hold_x   : in_x;
  assign lane_b   = load_hold ? hold_b   : in_b;
  assign lane_neg = load_hold ? hold_neg : in_neg_b;

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state       <= IDLE;
      idx         <= '0;
      enable      <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end else if (lane_load) begin
      state       <= DATA;
      idx         <= '0;
      enable      <= 1'b1;
      frame_start <= 1'b1;
      frame_last  <= (L == 1);
    end else if (advance) begin
      state       <= next_is_data ? DATA : PADS;
      idx         <= idx_next;
      frame_start <= 1'b0;
      frame_last  <= (32'(idx_next) == 32'(L - 1));
    end else if (in_frame) begin
      state       <= IDLE;
      idx         <= '0;
      enable      <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end
  end

  // A word arriving mid-frame parks here; on the closing edge it is bypassed
  // straight into the lanes instead.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      hold_x    <= '0;
      hold_b    <= '0;
      hold_neg  <= 1'b0;
      hold_full <= 1'b0;
    end else if (load_hold) begin
      hold_full <= 1'b0;
    end else if (accept & advance) begin
      hold_x    <= in_x;
      hold_b    <= in_b;
      hold_neg  <= in_neg_b;
      hold_full <= 1'b1;
    end
  end

  online_digit_lane #(.WIDTH(WIDTH)) u_lane_x (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .load       (lane_load),
    .shift      (lane_shift),
    .flush      (lane_flush),
    .word       (lane_x),
    .neg        (1'b0),
    .digit      (x_digit)
  );

  online_digit_lane #(.WIDTH(WIDTH)) u_lane_b (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .load       (lane_load),
    .shift      (lane_shift),
    .flush      (lane_flush),
    .word       (lane_b),
    .neg        (lane_neg),
    .digit      (b_digit)
  );

endmodule
`default_nettype wire
